// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with integrated ALU decode, memory handshake and traps.
// Latency: outputs are decoded from the current state (plus mem_ready in wait states), no output register.
// Backpressure: FETCH/MEMRD/MEMWR hold while mem_ready is low; a bounded stall (MEM_TIMEOUT) traps.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   opcode, funct   instruction fields from the instruction register
//   mem_ready       memory completes the current access this cycle
//   mem_req         memory access requested (FETCH, MEMRD, MEMWR)
//   pc_write        unconditional PC load; branch: PC load if ALU zero
//   memWrite        memory write strobe; iRwrite: instruction register load
//   regWrite        register file write; regDst: 0 = rt, 1 = rd; memToReg: 0 = ALUOut, 1 = mem data
//   IorD            0 = PC address, 1 = ALUOut address
//   aluSrc_a        0 = PC, 1 = A; aluSrc_b: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   pc_src          00 = ALUResult, 01 = ALUOut, 10 = jump target
//   alu_cntrl       010 add, 110 sub, 000 and, 001 or, 111 slt
//   instr_done      one-cycle pulse in the last state of each instruction
//   illegal         sticky: undefined opcode/funct trapped
//   mem_err         sticky: memory wait timeout trapped
//   state_o         current state encoding (debug)
//   branch_ne       (only with CTRL_BNE_EN) branch on ALU not-zero
//
// Build option: define CTRL_BNE_EN to decode opcode 000101 as bne and add the branch_ne port;
// without it, 000101 is treated as an illegal opcode.

module mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 15,
   parameter int ALU_CTRL_W  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  pc_write,
   output logic                  branch,
   output logic                  memWrite,
   output logic                  iRwrite,
   output logic                  regWrite,
   output logic                  IorD,
   output logic                  regDst,
   output logic                  memToReg,
   output logic                  aluSrc_a,
   output logic [1:0]            aluSrc_b,
   output logic [1:0]            pc_src,
   output logic [ALU_CTRL_W-1:0] alu_cntrl,
   output logic                  instr_done,
   output logic                  illegal,
   output logic                  mem_err,
`ifdef CTRL_BNE_EN
   output logic                  branch_ne,
`endif
   output logic [3:0]            state_o
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMRD    = 4'd4,
      MEMWB    = 4'd5,
      MEMWR    = 4'd6,
      RTYPE_EX = 4'd7,
      RTYPE_WB = 4'd8,
      BEQ      = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11,
      JUMP     = 4'd12,
      TRAP     = 4'd13
`ifdef CTRL_BNE_EN
      ,
      BNE      = 4'd14
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

   // Wide enough to hold MEM_TIMEOUT; at least one bit so a zero timeout still elaborates.
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   wait_cnt;
   logic               wait_state;
   logic               timeout;
   logic               set_illegal;
   logic               set_mem_err;
   logic               illegal_flag;
   logic               mem_err_flag;
   logic               funct_ok;
   logic [ALU_CTRL_W-1:0] rtype_alu;

   assign wait_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

   // wait_cnt holds the stall cycles already spent in this access, so the current
   // stalled cycle is number wait_cnt+1. A ready cycle never times out.
   assign timeout = (MEM_TIMEOUT != 0) && wait_state && !mem_ready &&
                    ((int'(wait_cnt) + 1) >= MEM_TIMEOUT);

   // R-type function decode, shared by the next-state check and the ALU output.
   always_comb begin
      funct_ok  = 1'b1;
      rtype_alu = ALU_AND;
      case (funct)
         FN_ADD:  rtype_alu = ALU_ADD;
         FN_SUB:  rtype_alu = ALU_SUB;
         FN_AND:  rtype_alu = ALU_AND;
         FN_OR:   rtype_alu = ALU_OR;
         FN_SLT:  rtype_alu = ALU_SLT;
         default: funct_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         illegal_flag <= 1'b0;
         mem_err_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         // Any state change restarts the count, so each wait state starts from zero.
         if (state_nxt != state)
            wait_cnt <= '0;
         else if (wait_state && !mem_ready && (wait_cnt != '1))
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (set_illegal)
            illegal_flag <= 1'b1;
         if (set_mem_err)
            mem_err_flag <= 1'b1;
      end
   end

   // Next-state logic and trap flag requests.
   always_comb begin
      state_nxt   = state;
      set_illegal = 1'b0;
      set_mem_err = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            if (mem_ready) begin
               state_nxt = DECODE;
            end else if (timeout) begin
               state_nxt   = TRAP;
               set_mem_err = 1'b1;
            end
         end
         DECODE: begin
            case (opcode)
               OP_RTYPE:     state_nxt = RTYPE_EX;
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_BEQ:       state_nxt = BEQ;
               OP_ADDI:      state_nxt = ADDI_EX;
               OP_J:         state_nxt = JUMP;
`ifdef CTRL_BNE_EN
               OP_BNE:       state_nxt = BNE;
`endif
               default: begin
                  state_nxt   = TRAP;
                  set_illegal = 1'b1;
               end
            endcase
         end
         // Only lw and sw reach MEMADR, so anything other than lw is a store.
         MEMADR: state_nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD: begin
            if (mem_ready) begin
               state_nxt = MEMWB;
            end else if (timeout) begin
               state_nxt   = TRAP;
               set_mem_err = 1'b1;
            end
         end
         MEMWB: state_nxt = FETCH;
         MEMWR: begin
            if (mem_ready) begin
               state_nxt = FETCH;
            end else if (timeout) begin
               state_nxt   = TRAP;
               set_mem_err = 1'b1;
            end
         end
         RTYPE_EX: begin
            if (funct_ok) begin
               state_nxt = RTYPE_WB;
            end else begin
               state_nxt   = TRAP;
               set_illegal = 1'b1;
            end
         end
         RTYPE_WB: state_nxt = FETCH;
         BEQ:      state_nxt = FETCH;
`ifdef CTRL_BNE_EN
         BNE:      state_nxt = FETCH;
`endif
         ADDI_EX:  state_nxt = ADDI_WB;
         ADDI_WB:  state_nxt = FETCH;
         JUMP:     state_nxt = FETCH;
         TRAP:     state_nxt = TRAP;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output decode. Everything defaults to 0; with the asynchronous reset forcing IDLE,
   // mem_req and the write strobes drop as soon as rst rises.
   always_comb begin
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      memWrite   = 1'b0;
      iRwrite    = 1'b0;
      regWrite   = 1'b0;
      IorD       = 1'b0;
      regDst     = 1'b0;
      memToReg   = 1'b0;
      aluSrc_a   = 1'b0;
      aluSrc_b   = 2'b00;
      pc_src     = 2'b00;
      alu_cntrl  = '0;
      instr_done = 1'b0;
`ifdef CTRL_BNE_EN
      branch_ne  = 1'b0;
`endif
      case (state)
         FETCH: begin
            mem_req   = 1'b1;
            aluSrc_b  = 2'b01;
            alu_cntrl = ALU_ADD;
            // IR and PC load only in the cycle the fetch completes.
            iRwrite   = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            aluSrc_b  = 2'b11;
            alu_cntrl = ALU_ADD;
         end
         MEMADR: begin
            aluSrc_a  = 1'b1;
            aluSrc_b  = 2'b10;
            alu_cntrl = ALU_ADD;
         end
         MEMRD: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            regWrite   = 1'b1;
            memToReg   = 1'b1;
            instr_done = 1'b1;
         end
         MEMWR: begin
            mem_req    = 1'b1;
            IorD       = 1'b1;
            memWrite   = 1'b1;
            instr_done = mem_ready;
         end
         RTYPE_EX: begin
            aluSrc_a  = 1'b1;
            alu_cntrl = rtype_alu;
         end
         RTYPE_WB: begin
            regWrite   = 1'b1;
            regDst     = 1'b1;
            instr_done = 1'b1;
         end
         BEQ: begin
            aluSrc_a   = 1'b1;
            alu_cntrl  = ALU_SUB;
            branch     = 1'b1;
            pc_src     = 2'b01;
            instr_done = 1'b1;
         end
`ifdef CTRL_BNE_EN
         BNE: begin
            aluSrc_a   = 1'b1;
            alu_cntrl  = ALU_SUB;
            branch     = 1'b1;
            branch_ne  = 1'b1;
            pc_src     = 2'b01;
            instr_done = 1'b1;
         end
`endif
         ADDI_EX: begin
            aluSrc_a  = 1'b1;
            aluSrc_b  = 2'b10;
            alu_cntrl = ALU_ADD;
         end
         ADDI_WB: begin
            regWrite   = 1'b1;
            instr_done = 1'b1;
         end
         JUMP: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign illegal = illegal_flag;
   assign mem_err = mem_err_flag;
   assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: self-checking bench for mc_ctrl_fsm (MEM_TIMEOUT = 4).
// Directed cycle tables, hand-written reset/trap/timeout corners, and random instruction
// streams expanded per instruction into expected per-cycle outputs.

module tb_mc_ctrl_fsm;

   localparam int TO = 4;

   localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
                          S_MEMRD = 4'd4, S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_RTEX   = 4'd7,
                          S_RTWB  = 4'd8, S_BEQ    = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                          S_JUMP  = 4'd12, S_TRAP  = 4'd13, S_BNE    = 4'd14;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                          OP_BNE = 6'b000101;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req, pc_write, branch, branch_ne, memWrite, iRwrite, regWrite;
      logic       IorD, regDst, memToReg, aluSrc_a;
      logic [1:0] aluSrc_b, pc_src;
      logic [2:0] alu;
      logic       instr_done, illegal, mem_err;
   } out_t;

   typedef struct {
      logic       rst;
      logic [5:0] opcode;
      logic [5:0] funct;
      logic       mem_ready;
      out_t       exp;
      string      tag;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic mem_ready = 1'b0;
   logic mem_req, pc_write, branch, memWrite, iRwrite, regWrite, IorD, regDst, memToReg, aluSrc_a;
   logic [1:0] aluSrc_b, pc_src;
   logic [2:0] alu_cntrl;
   logic instr_done, illegal, mem_err;
   logic [3:0] state_o;
`ifdef CTRL_BNE_EN
   logic branch_ne;
`endif

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.MEM_TIMEOUT(TO), .ALU_CTRL_W(3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .mem_req(mem_req), .pc_write(pc_write), .branch(branch), .memWrite(memWrite),
      .iRwrite(iRwrite), .regWrite(regWrite), .IorD(IorD), .regDst(regDst),
      .memToReg(memToReg), .aluSrc_a(aluSrc_a), .aluSrc_b(aluSrc_b), .pc_src(pc_src),
      .alu_cntrl(alu_cntrl), .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err),
`ifdef CTRL_BNE_EN
      .branch_ne(branch_ne),
`endif
      .state_o(state_o)
   );

   int   vectors = 0;
   int   miscompares = 0;
   bit   m_ill = 1'b0;
   bit   m_merr = 1'b0;
   vec_t tbl[$];
   logic [5:0] legal_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   logic [5:0] bad_op[3]   = '{6'b111111, 6'b000011, 6'b010000};

   // Per-cycle outputs of each controller step as listed in the block description.
   function automatic out_t exp_out(input logic [3:0] ph, input logic rdy, input logic [2:0] alu);
      out_t o;
      o = '0;
      o.st = ph;
      case (ph)
         S_FETCH:  begin o.mem_req = 1; o.aluSrc_b = 2'b01; o.alu = 3'b010; o.iRwrite = rdy; o.pc_write = rdy; end
         S_DECODE: begin o.aluSrc_b = 2'b11; o.alu = 3'b010; end
         S_MEMADR: begin o.aluSrc_a = 1; o.aluSrc_b = 2'b10; o.alu = 3'b010; end
         S_MEMRD:  begin o.mem_req = 1; o.IorD = 1; end
         S_MEMWB:  begin o.regWrite = 1; o.memToReg = 1; o.instr_done = 1; end
         S_MEMWR:  begin o.mem_req = 1; o.IorD = 1; o.memWrite = 1; o.instr_done = rdy; end
         S_RTEX:   begin o.aluSrc_a = 1; o.alu = alu; end
         S_RTWB:   begin o.regWrite = 1; o.regDst = 1; o.instr_done = 1; end
         S_BEQ:    begin o.aluSrc_a = 1; o.alu = 3'b110; o.branch = 1; o.pc_src = 2'b01; o.instr_done = 1; end
         S_BNE:    begin o.aluSrc_a = 1; o.alu = 3'b110; o.branch = 1; o.branch_ne = 1; o.pc_src = 2'b01; o.instr_done = 1; end
         S_ADDIEX: begin o.aluSrc_a = 1; o.aluSrc_b = 2'b10; o.alu = 3'b010; end
         S_ADDIWB: begin o.regWrite = 1; o.instr_done = 1; end
         S_JUMP:   begin o.pc_write = 1; o.pc_src = 2'b10; o.instr_done = 1; end
         default:  ;
      endcase
      o.illegal = m_ill;
      o.mem_err = m_merr;
      return o;
   endfunction

   function automatic bit rt_alu(input logic [5:0] fn, output logic [2:0] alu);
      alu = 3'b000;
      case (fn)
         6'b100000: begin alu = 3'b010; return 1'b1; end
         6'b100010: begin alu = 3'b110; return 1'b1; end
         6'b100100: begin alu = 3'b000; return 1'b1; end
         6'b100101: begin alu = 3'b001; return 1'b1; end
         6'b101010: begin alu = 3'b111; return 1'b1; end
         default:   return 1'b0;
      endcase
   endfunction

   function automatic out_t get_out();
      out_t o;
      o.st = state_o;         o.mem_req = mem_req;   o.pc_write = pc_write; o.branch = branch;
      o.memWrite = memWrite;  o.iRwrite = iRwrite;   o.regWrite = regWrite; o.IorD = IorD;
      o.regDst = regDst;      o.memToReg = memToReg; o.aluSrc_a = aluSrc_a; o.aluSrc_b = aluSrc_b;
      o.pc_src = pc_src;      o.alu = alu_cntrl;     o.instr_done = instr_done;
      o.illegal = illegal;    o.mem_err = mem_err;
`ifdef CTRL_BNE_EN
      o.branch_ne = branch_ne;
`else
      o.branch_ne = 1'b0;
`endif
      return o;
   endfunction

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input logic [3:0] ph, input logic [2:0] alu, input string tag);
      vec_t v;
      v.rst = r; v.opcode = op; v.funct = fn; v.mem_ready = rdy;
      v.exp = exp_out(ph, rdy, alu);
      v.tag = tag;
      tbl.push_back(v);
   endtask

   task automatic push_reset();
      m_ill  = 1'b0;
      m_merr = 1'b0;
      push(1'b1, 6'd0, 6'd0, 1'b0, S_IDLE, 3'b000, "reset");
      push(1'b0, 6'd0, 6'd0, 1'b0, S_IDLE, 3'b000, "idle");
   endtask

   task automatic push_trap(input int n, input logic [5:0] op, input logic [5:0] fn);
      for (int i = 0; i < n; i++) push(1'b0, op, fn, rb(), S_TRAP, 3'b000, "trap");
      push_reset();
   endtask

   // A memory wait of n stalled cycles followed by completion, or a timeout trap.
   task automatic wait_phase(input logic [3:0] ph, input int n, input logic [5:0] op,
                             input logic [5:0] fn, output bit trapped);
      trapped = 1'b0;
      for (int i = 0; i < n; i++) begin
         push(1'b0, op, fn, 1'b0, ph, 3'b000, "stall");
         if (TO != 0 && i + 1 == TO) begin
            m_merr  = 1'b1;
            trapped = 1'b1;
            return;
         end
      end
      push(1'b0, op, fn, 1'b1, ph, 3'b000, "ready");
   endtask

   // Instruction-level reference: expands one instruction into its expected cycles.
   task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int fst, input int dst);
      bit tr;
      logic [2:0] alu;
      wait_phase(S_FETCH, fst, op, fn, tr);
      if (tr) begin push_trap(2, op, fn); return; end
      push(1'b0, op, fn, rb(), S_DECODE, 3'b000, "decode");
      case (op)
         OP_R: begin
            if (rt_alu(fn, alu)) begin
               push(1'b0, op, fn, rb(), S_RTEX, alu, "rtex");
               push(1'b0, op, fn, rb(), S_RTWB, 3'b000, "rtwb");
            end else begin
               push(1'b0, op, fn, rb(), S_RTEX, 3'b000, "rtex_bad");
               m_ill = 1'b1;
               push_trap(2, op, fn);
            end
         end
         OP_LW: begin
            push(1'b0, op, fn, rb(), S_MEMADR, 3'b000, "memadr");
            wait_phase(S_MEMRD, dst, op, fn, tr);
            if (tr) push_trap(2, op, fn);
            else    push(1'b0, op, fn, rb(), S_MEMWB, 3'b000, "memwb");
         end
         OP_SW: begin
            push(1'b0, op, fn, rb(), S_MEMADR, 3'b000, "memadr");
            wait_phase(S_MEMWR, dst, op, fn, tr);
            if (tr) push_trap(2, op, fn);
         end
         OP_BEQ:  push(1'b0, op, fn, rb(), S_BEQ, 3'b000, "beq");
         OP_J:    push(1'b0, op, fn, rb(), S_JUMP, 3'b000, "jump");
         OP_ADDI: begin
            push(1'b0, op, fn, rb(), S_ADDIEX, 3'b000, "addiex");
            push(1'b0, op, fn, rb(), S_ADDIWB, 3'b000, "addiwb");
         end
`ifdef CTRL_BNE_EN
         OP_BNE:  push(1'b0, op, fn, rb(), S_BNE, 3'b000, "bne");
`endif
         default: begin
            m_ill = 1'b1;
            push_trap(2, op, fn);
         end
      endcase
   endtask

   task automatic check(input string name, input out_t exp);
      out_t act;
      act = get_out();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive each row just after the rising edge, compare on the falling edge.
   task automatic run_table();
      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         rst = tbl[i].rst; opcode = tbl[i].opcode; funct = tbl[i].funct; mem_ready = tbl[i].mem_ready;
         @(negedge clk);
         check($sformatf("%s row %0d", tbl[i].tag, i), tbl[i].exp);
      end
      tbl.delete();
   endtask

   initial begin
      int k, fst, dst;
      logic [5:0] op, fn;

      // Directed cycle table: add, sub, slt, lw with 3-cycle read, beq, j, addi.
      push_reset();
      push(0, OP_R, 6'b100000, 1, S_FETCH, 0, "add_f");  push(0, OP_R, 6'b100000, 0, S_DECODE, 0, "add_d");
      push(0, OP_R, 6'b100000, 0, S_RTEX, 3'b010, "add_ex"); push(0, OP_R, 6'b100000, 1, S_RTWB, 0, "add_wb");
      push(0, OP_R, 6'b100010, 1, S_FETCH, 0, "sub_f");  push(0, OP_R, 6'b100010, 1, S_DECODE, 0, "sub_d");
      push(0, OP_R, 6'b100010, 0, S_RTEX, 3'b110, "sub_ex"); push(0, OP_R, 6'b100010, 0, S_RTWB, 0, "sub_wb");
      push(0, OP_R, 6'b101010, 1, S_FETCH, 0, "slt_f");  push(0, OP_R, 6'b101010, 0, S_DECODE, 0, "slt_d");
      push(0, OP_R, 6'b101010, 1, S_RTEX, 3'b111, "slt_ex"); push(0, OP_R, 6'b101010, 0, S_RTWB, 0, "slt_wb");
      push(0, OP_LW, 0, 1, S_FETCH, 0, "lw_f");   push(0, OP_LW, 0, 0, S_DECODE, 0, "lw_d");
      push(0, OP_LW, 0, 0, S_MEMADR, 0, "lw_adr");
      push(0, OP_LW, 0, 0, S_MEMRD, 0, "lw_rd1"); push(0, OP_LW, 0, 0, S_MEMRD, 0, "lw_rd2");
      push(0, OP_LW, 0, 0, S_MEMRD, 0, "lw_rd3"); push(0, OP_LW, 0, 1, S_MEMRD, 0, "lw_rd4");
      push(0, OP_LW, 0, 0, S_MEMWB, 0, "lw_wb");
      push(0, OP_BEQ, 0, 1, S_FETCH, 0, "beq_f"); push(0, OP_BEQ, 0, 0, S_DECODE, 0, "beq_d");
      push(0, OP_BEQ, 0, 0, S_BEQ, 0, "beq");
      push(0, OP_J, 0, 1, S_FETCH, 0, "j_f");     push(0, OP_J, 0, 0, S_DECODE, 0, "j_d");
      push(0, OP_J, 0, 1, S_JUMP, 0, "jump");
      push(0, OP_ADDI, 0, 1, S_FETCH, 0, "addi_f"); push(0, OP_ADDI, 0, 0, S_DECODE, 0, "addi_d");
      push(0, OP_ADDI, 0, 0, S_ADDIEX, 0, "addi_ex"); push(0, OP_ADDI, 0, 0, S_ADDIWB, 0, "addi_wb");
      run_table();

      // Illegal opcode: trap with illegal set, no memory request for 20 cycles.
      push(0, 6'b111111, 0, 1, S_FETCH, 0, "ill_f"); push(0, 6'b111111, 0, 0, S_DECODE, 0, "ill_d");
      m_ill = 1'b1;
      for (int i = 0; i < 20; i++) push(0, 6'b111111, 0, rb(), S_TRAP, 0, "ill_trap");
      push_reset();
      // Fetch that never completes: four stalled FETCH cycles, then mem_err trap.
      for (int i = 0; i < TO; i++) push(0, OP_J, 0, 0, S_FETCH, 0, "to_fetch");
      m_merr = 1'b1;
      for (int i = 0; i < 3; i++) push(0, OP_J, 0, rb(), S_TRAP, 0, "to_trap");
      push_reset();
      // Ready on the cycle the count would expire wins.
      for (int i = 0; i < TO - 1; i++) push(0, OP_J, 0, 0, S_FETCH, 0, "win_stall");
      push(0, OP_J, 0, 1, S_FETCH, 0, "win_ready"); push(0, OP_J, 0, 0, S_DECODE, 0, "win_d");
      push(0, OP_J, 0, 0, S_JUMP, 0, "win_jump");
      // Unknown funct traps after RTYPE_EX.
      push(0, OP_R, 6'b111111, 1, S_FETCH, 0, "badfn_f"); push(0, OP_R, 6'b111111, 0, S_DECODE, 0, "badfn_d");
      push(0, OP_R, 6'b111111, 0, S_RTEX, 3'b000, "badfn_ex");
      m_ill = 1'b1;
      push(0, OP_R, 6'b111111, 0, S_TRAP, 0, "badfn_trap");
      push_reset();
      // bne: decoded only when the option is built in.
      gen_instr(OP_BNE, 6'd0, 0, 0);
      run_table();

      // Asynchronous reset in the middle of a stalled store.
      push_reset();
      push(0, OP_SW, 0, 1, S_FETCH, 0, "sw_f"); push(0, OP_SW, 0, 0, S_DECODE, 0, "sw_d");
      push(0, OP_SW, 0, 0, S_MEMADR, 0, "sw_adr");
      push(0, OP_SW, 0, 0, S_MEMWR, 0, "sw_wait1"); push(0, OP_SW, 0, 0, S_MEMWR, 0, "sw_wait2");
      run_table();
      @(posedge clk);
      #2;
      check("memwr_before_rst", exp_out(S_MEMWR, 1'b0, 3'b000));
      rst = 1'b1;
      #1;
      check("async_rst_outputs", exp_out(S_IDLE, 1'b0, 3'b000));
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_release", exp_out(S_IDLE, 1'b0, 3'b000));
      @(negedge clk);
      check("fetch_after_release", exp_out(S_FETCH, 1'b0, 3'b000));

      // Random instruction stream against the instruction-level reference.
      push_reset();
      run_table();
      for (int n = 0; n < 300; n++) begin
         k  = int'($urandom_range(0, 12));
         fn = legal_fn[$urandom_range(0, 4)];
         case (k)
            0, 1, 2, 3, 4: op = OP_R;
            5:  begin op = OP_R; fn = ($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b100001; end
            6:  op = OP_LW;
            7:  op = OP_SW;
            8:  op = OP_BEQ;
            9:  op = OP_J;
            10: op = OP_ADDI;
            11: op = bad_op[$urandom_range(0, 2)];
            default: op = OP_BNE;
         endcase
         fst = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
         dst = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
         gen_instr(op, fn, fst, dst);
         run_table();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
